// File: rtl/adc_serial_ctrl_multi_if.sv
// Signal bundle between the multi-channel ADC readout controller, the ADC pins
// and the host side.
// Handshake: adc_valid is a single-cycle pulse with no back-pressure; adc_data
// is valid in that cycle and holds until the next result. adc_ready is high only
// while the controller sits in IDLE, where a rising start edge (or continuous=1)
// launches the next result block.
interface adc_serial_ctrl_multi_if #(
  parameter int DATA_W = 14,
  parameter int N_CH   = 2
);
  logic                   SCLK;
  logic                   CNVST;
  logic                   CS;
  logic                   BUSY;
  logic [N_CH-1:0]        DOUT;
  logic                   start;
  logic                   continuous;
  logic [1:0]             avg_log2;
  logic [N_CH*DATA_W-1:0] adc_data;
  logic                   adc_valid;
  logic                   adc_ready;
  logic                   err_timeout;

  // Controller side
  modport master (
    output SCLK, CNVST, CS, adc_data, adc_valid, adc_ready, err_timeout,
    input  BUSY, DOUT, start, continuous, avg_log2
  );

  // ADC model / host side
  modport slave (
    input  SCLK, CNVST, CS, adc_data, adc_valid, adc_ready, err_timeout,
    output BUSY, DOUT, start, continuous, avg_log2
  );
endinterface

// File: rtl/adc_serial_ctrl_multi.sv
// Readout controller for a simultaneous-sampling serial ADC with N_CH data
// lines. Runs CNVST -> BUSY wait -> MSB-first serial read -> quiet gap, and
// optionally averages 2^avg_log2 conversions into one result per channel.
// Every pin and status output is a flop loaded from the FSM's next state, so
// outputs line up with the state register visible on debug_state.
module adc_serial_ctrl_multi #(
  parameter int DATA_W       = 14,
  parameter int N_CH         = 2,
  parameter int SCLK_HALF    = 2,
  parameter int CNV_LOW      = 1,
  parameter int CNV_WAIT     = 6,
  parameter int QUIET        = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  adc_serial_ctrl_multi_if.master        bus,
  output logic [2:0]                     debug_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_READ      = 3'd3,
    S_QUIET     = 3'd4,
    S_ACC       = 3'd5
  } state_t;

  // Accumulator holds up to 8 samples without overflow.
  localparam int ACC_W   = DATA_W + 3;
  localparam int CNT_MAX = (BUSY_TIMEOUT > CNV_WAIT)
                         ? ((BUSY_TIMEOUT > QUIET) ? BUSY_TIMEOUT : QUIET)
                         : ((CNV_WAIT > QUIET) ? CNV_WAIT : QUIET);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(2 * SCLK_HALF);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNV_LOW_C   = CNT_W'(CNV_LOW);
  localparam logic [CNT_W-1:0] CNV_END_C   = CNT_W'(CNV_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_END_C   = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] QUIET_END_C = CNT_W'(QUIET - 1);
  localparam logic [PH_W-1:0]  PH_LOW_C    = PH_W'(SCLK_HALF);
  localparam logic [PH_W-1:0]  PH_END_C    = PH_W'(2 * SCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_END_C   = BIT_W'(DATA_W - 1);

  // FSM and sequencing registers
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;         // phase count in CONV / WAIT_BUSY / QUIET
  logic [PH_W-1:0]    ph, ph_n;           // SCLK phase within one bit
  logic [BIT_W-1:0]   bit_idx, bit_n;     // bits shifted so far
  logic               tmo_q, tmo_n;       // current block aborted by BUSY timeout
  logic               start_d;

  // Registered outputs and their next values
  logic                   sclk_q, sclk_n;
  logic                   cnvst_q, cnvst_n;
  logic                   cs_q, cs_n;
  logic [N_CH*DATA_W-1:0] data_q, data_n;
  logic                   valid_q, valid_n;
  logic                   ready_q, ready_n;
  logic                   err_q, err_n;

  // Datapath
  logic [DATA_W-1:0] sreg [N_CH];
  logic [ACC_W-1:0]  acc  [N_CH];
  logic [ACC_W-1:0]  sum  [N_CH];
  logic [2:0]        sample_cnt;
  logic [1:0]        avg_q;
  logic [3:0]        n_target;
  logic              last_sample;
  logic              go;

  // Launch condition seen in IDLE: a fresh start edge or free-running mode.
  assign go          = (bus.start & ~start_d) | bus.continuous;
  assign n_target    = 4'd1 << avg_q;
  assign last_sample = ({1'b0, sample_cnt} + 4'd1) == n_target;

  // Running total including the sample just read, used for the final result.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      sum[k] = acc[k] + ACC_W'(sreg[k]);
    end
  end

  // Next-state logic plus next values of all registered outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    bit_n   = bit_idx;
    tmo_n   = tmo_q;
    err_n   = err_q;
    valid_n = 1'b0;
    data_n  = data_q;

    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_CONV;
          cnt_n   = '0;
          tmo_n   = 1'b0;
          err_n   = 1'b0;
        end
      end
      S_CONV: begin
        if (cnt == CNV_END_C) begin
          state_n = S_WAIT_BUSY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.BUSY) begin
          state_n = S_READ;
          ph_n    = '0;
          bit_n   = '0;
        end else if (cnt == TMO_END_C) begin
          // Abandon the block: pass through QUIET so CS recovery time is kept.
          state_n = S_QUIET;
          cnt_n   = '0;
          tmo_n   = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_READ: begin
        if (ph == PH_END_C) begin
          ph_n  = '0;
          bit_n = bit_idx + BIT_W'(1);
          if (bit_idx == BIT_END_C) begin
            state_n = S_QUIET;
            cnt_n   = '0;
          end
        end else begin
          ph_n = ph + PH_W'(1);
        end
      end
      S_QUIET: begin
        if (cnt == QUIET_END_C) begin
          if (tmo_q) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_ACC;
            // The result lands in the ACC cycle itself, together with adc_valid.
            if (last_sample) begin
              valid_n = 1'b1;
              for (int k = 0; k < N_CH; k++) begin
                data_n[k*DATA_W +: DATA_W] = DATA_W'(sum[k] >> avg_q);
              end
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_ACC: begin
        if (last_sample) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_CONV;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Pin levels follow the state being entered so they align with debug_state.
    sclk_n  = !((state_n == S_READ) && (ph_n != '0) && (ph_n <= PH_LOW_C));
    cnvst_n = !((state_n == S_CONV) && (cnt_n < CNV_LOW_C));
    cs_n    = (state_n != S_READ);
    ready_n = (state_n == S_IDLE);
  end

  // State register, sequencing counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ph      <= '0;
      bit_idx <= '0;
      tmo_q   <= 1'b0;
      start_d <= 1'b0;
      sclk_q  <= 1'b1;
      cnvst_q <= 1'b1;
      cs_q    <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ph      <= ph_n;
      bit_idx <= bit_n;
      tmo_q   <= tmo_n;
      start_d <= bus.start;
      sclk_q  <= sclk_n;
      cnvst_q <= cnvst_n;
      cs_q    <= cs_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ready_q <= ready_n;
      err_q   <= err_n;
    end
  end

  // Shift registers, accumulators, sample count and the per-block average setting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_cnt <= '0;
      avg_q      <= '0;
      for (int k = 0; k < N_CH; k++) begin
        sreg[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      if (state == S_IDLE && go) begin
        // avg_log2 is frozen here so mid-block changes have no effect.
        avg_q      <= bus.avg_log2;
        sample_cnt <= '0;
        for (int k = 0; k < N_CH; k++) begin
          acc[k] <= '0;
        end
      end
      if (state == S_READ && ph == '0) begin
        for (int k = 0; k < N_CH; k++) begin
          sreg[k] <= {sreg[k][DATA_W-2:0], bus.DOUT[k]};
        end
      end
      if (state == S_ACC) begin
        sample_cnt <= sample_cnt + 3'd1;
        for (int k = 0; k < N_CH; k++) begin
          acc[k] <= sum[k];
        end
      end
    end
  end

  assign bus.SCLK        = sclk_q;
  assign bus.CNVST       = cnvst_q;
  assign bus.CS          = cs_q;
  assign bus.adc_data    = data_q;
  assign bus.adc_valid   = valid_q;
  assign bus.adc_ready   = ready_q;
  assign bus.err_timeout = err_q;
  assign debug_state     = state;

endmodule

// File: tb/tb_adc_serial_ctrl_multi.sv
// Bench for adc_serial_ctrl_multi: behavioural ADC model, start/continuous
// drivers, and a result scoreboard fed with averages computed from the raw
// conversion values that the ADC model later plays out.
module tb_adc_serial_ctrl_multi;

  localparam int DATA_W       = 14;
  localparam int N_CH         = 2;
  localparam int SCLK_HALF    = 2;
  localparam int CNV_LOW      = 1;
  localparam int CNV_WAIT     = 6;
  localparam int QUIET        = 4;
  localparam int BUSY_TIMEOUT = 255;
  localparam int NW           = N_CH * DATA_W;
  localparam int READ_CYC     = DATA_W * 2 * SCLK_HALF;
  localparam int LAT          = 1 + CNV_WAIT + 1 + READ_CYC + QUIET;
  localparam int PERIOD       = LAT + 1;
  localparam logic [NW-1:0] T1_EXP = {14'h1555, 14'h2AAA};

  logic       CLK;
  logic       RST;
  logic [2:0] debug_state;

  adc_serial_ctrl_multi_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  adc_serial_ctrl_multi #(
    .DATA_W(DATA_W), .N_CH(N_CH), .SCLK_HALF(SCLK_HALF), .CNV_LOW(CNV_LOW),
    .CNV_WAIT(CNV_WAIT), .QUIET(QUIET), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .debug_state(debug_state)
  );

  // Scoreboard and bookkeeping
  logic [NW-1:0]     exp_q [$];
  logic [NW-1:0]     conv_q [$];
  int                valid_cyc_q [$];
  logic [DATA_W-1:0] smp [8][N_CH];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int cnv_pulses = 0;
  int cs_run = 0;
  int last_cs_run = 0;
  int cs_low_total = 0;
  int wb_run = 0;
  int last_wb_run = 0;
  int busy_len = 3;
  int adc_bit = 0;
  int start_cyc = 0;
  logic busy_stuck = 1'b0;

  // Clock and cycle counter
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  initial begin
    #(600_000);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ADC model: BUSY pulse after each CNVST fall, new bit after each SCLK fall.
  initial begin : adc_model
    logic          prev_cnvst;
    logic          prev_sclk;
    int            busy_cnt;
    int            idx;
    logic [NW-1:0] word;
    prev_cnvst = 1'b1;
    prev_sclk  = 1'b1;
    busy_cnt   = 0;
    idx        = 0;
    word       = '0;
    bus.BUSY   = 1'b0;
    bus.DOUT   = '0;
    forever begin
      @(negedge CLK);
      if (prev_cnvst && !bus.CNVST) begin
        cnv_pulses++;
        if (conv_q.size() > 0) word = conv_q.pop_front();
        else word = '0;
        bus.BUSY = 1'b1;
        busy_cnt = busy_len;
      end else if (bus.BUSY && !busy_stuck) begin
        if (busy_cnt <= 1) bus.BUSY = 1'b0;
        else busy_cnt--;
      end
      if (bus.CS) idx = 0;
      else if (prev_sclk && !bus.SCLK) idx++;
      adc_bit = idx;
      for (int k = 0; k < N_CH; k++) begin
        if (idx < DATA_W) bus.DOUT[k] = word[k*DATA_W + DATA_W - 1 - idx];
        else bus.DOUT[k] = 1'b0;
      end
      prev_cnvst = bus.CNVST;
      prev_sclk  = bus.SCLK;
    end
  end

  // Monitor: pops the scoreboard on every result and tracks CS / WAIT_BUSY spans.
  initial begin : monitor
    logic [NW-1:0] exp_v;
    forever begin
      @(negedge CLK);
      if (bus.adc_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        valid_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_valid: got=%0h expected=no_result", bus.adc_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("adc_data", bus.adc_data, exp_v);
        end
      end
      if (!bus.CS) begin
        cs_run++;
        cs_low_total++;
      end else if (cs_run != 0) begin
        last_cs_run = cs_run;
        cs_run = 0;
      end
      if (debug_state == 3'd2) wb_run++;
      else if (wb_run != 0) begin
        last_wb_run = wb_run;
        wb_run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic randomize_smp();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < N_CH; k++)
        smp[i][k] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endtask

  // Reference: per-channel mean of 2^avg raw samples, rounded down.
  task automatic queue_block(input int avg, input bit want_result);
    logic [NW-1:0] word;
    logic [NW-1:0] res;
    int            total;
    int            n;
    n   = 1 << avg;
    res = '0;
    for (int k = 0; k < N_CH; k++) begin
      total = 0;
      for (int i = 0; i < n; i++) total += int'(smp[i][k]);
      res[k*DATA_W +: DATA_W] = DATA_W'(total / n);
    end
    for (int i = 0; i < n; i++) begin
      word = '0;
      for (int k = 0; k < N_CH; k++) word[k*DATA_W +: DATA_W] = smp[i][k];
      conv_q.push_back(word);
    end
    if (want_result) exp_q.push_back(res);
  endtask

  task automatic start_block(input int avg);
    bus.avg_log2 = 2'(avg);
    bus.start    = 1'b1;
    start_cyc    = cyc;
    tick(1);
    bus.start    = 1'b0;
    bus.avg_log2 = 2'($urandom_range(0, 3));
  endtask

  task automatic finish_block(input int bound, input string name);
    int n;
    n = 0;
    while (bus.adc_ready !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    check({name, "_ready_back"}, bus.adc_ready, 1'b1);
  endtask

  task automatic wait_valids(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (valid_cnt < target && n < bound) begin
      tick(1);
      n++;
    end
    check({name, "_valid_count"}, valid_cnt, target);
  endtask

  initial begin : main
    int v0, p0, c0, n, avg;
    RST             = 1'b1;
    bus.start       = 1'b0;
    bus.continuous  = 1'b0;
    bus.avg_log2    = 2'd0;
    tick(3);

    // Reset state: first cycle after release still shows reset values.
    RST = 1'b0;
    check("rst_sclk", bus.SCLK, 1'b1);
    check("rst_cnvst", bus.CNVST, 1'b1);
    check("rst_cs", bus.CS, 1'b1);
    check("rst_data", bus.adc_data, '0);
    check("rst_valid", bus.adc_valid, 1'b0);
    check("rst_ready_first", bus.adc_ready, 1'b0);
    check("rst_err", bus.err_timeout, 1'b0);
    tick(1);
    check("rst_ready_second", bus.adc_ready, 1'b1);
    check("rst_state", debug_state, 3'd0);

    // Single shot with fixed patterns and a late BUSY release.
    busy_len = 10;
    smp[0][0] = 14'h2AAA;
    smp[0][1] = 14'h1555;
    v0 = valid_cnt; p0 = cnv_pulses; c0 = cs_low_total;
    queue_block(0, 1'b1);
    start_block(0);
    check("t1_ready_low", bus.adc_ready, 1'b0);
    finish_block(2000, "t1");
    check("t1_data_const", bus.adc_data, T1_EXP);
    check("t1_valids", valid_cnt - v0, 1);
    check("t1_cnvst", cnv_pulses - p0, 1);
    check("t1_cs_run", last_cs_run, READ_CYC);
    check("t1_cs_total", cs_low_total - c0, READ_CYC);

    // Start-to-result latency with BUSY already low at WAIT_BUSY.
    busy_len = 2;
    randomize_smp();
    queue_block(0, 1'b1);
    start_block(0);
    finish_block(2000, "lat");
    check("latency", last_valid_cyc - start_cyc, LAT);

    // Average of four samples on channel 0.
    busy_len = 5;
    randomize_smp();
    smp[0][0] = 14'd100; smp[1][0] = 14'd101; smp[2][0] = 14'd102; smp[3][0] = 14'd104;
    v0 = valid_cnt; p0 = cnv_pulses;
    queue_block(2, 1'b1);
    start_block(2);
    finish_block(2000, "avg4");
    check("avg4_ch0", bus.adc_data[DATA_W-1:0], 101);
    check("avg4_valids", valid_cnt - v0, 1);
    check("avg4_cnvst", cnv_pulses - p0, 4);

    // Random blocks, plus full-scale and all-zero corners.
    for (int i = 0; i < 6; i++) begin
      avg = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 12);
      randomize_smp();
      if (i == 0) begin
        avg = 3;
        for (int s = 0; s < 8; s++)
          for (int k = 0; k < N_CH; k++) smp[s][k] = '1;
      end else if (i == 1) begin
        avg = 1;
        for (int s = 0; s < 8; s++)
          for (int k = 0; k < N_CH; k++) smp[s][k] = '0;
      end
      p0 = cnv_pulses;
      queue_block(avg, 1'b1);
      start_block(avg);
      finish_block(3000, "rand");
      check("rand_cnvst", cnv_pulses - p0, 1 << avg);
    end

    // BUSY stuck high: timeout, no readout, sticky error cleared by next start.
    busy_stuck = 1'b1;
    v0 = valid_cnt; c0 = cs_low_total;
    start_block(0);
    finish_block(1000, "tmo");
    check("tmo_err", bus.err_timeout, 1'b1);
    check("tmo_wait_len", last_wb_run, BUSY_TIMEOUT);
    check("tmo_cs_never_low", cs_low_total - c0, 0);
    check("tmo_no_valid", valid_cnt - v0, 0);
    tick(5);
    check("tmo_err_sticky", bus.err_timeout, 1'b1);
    busy_stuck = 1'b0;
    busy_len = 3;
    tick(2);
    randomize_smp();
    queue_block(0, 1'b1);
    start_block(0);
    check("tmo_err_cleared", bus.err_timeout, 1'b0);
    finish_block(2000, "tmo_next");

    // Continuous mode: constant period, then drop continuous mid-READ.
    busy_len = 3;
    for (int b = 0; b < 4; b++) begin
      randomize_smp();
      queue_block(0, 1'b1);
    end
    valid_cyc_q.delete();
    v0 = valid_cnt;
    bus.avg_log2 = 2'd0;
    bus.continuous = 1'b1;
    wait_valids(v0 + 3, 1000, "cont3");
    n = 0;
    while (debug_state != 3'd3 && n < 200) begin
      tick(1);
      n++;
    end
    check("cont_in_read", debug_state, 3'd3);
    bus.continuous = 1'b0;
    tick(2);
    finish_block(400, "cont");
    check("cont_valids", valid_cnt - v0, 4);
    for (int i = 0; i + 1 < valid_cyc_q.size(); i++)
      check("cont_period", valid_cyc_q[i+1] - valid_cyc_q[i], PERIOD);
    tick(100);
    check("cont_stays_idle", bus.adc_ready, 1'b1);
    check("cont_no_more", valid_cnt - v0, 4);

    // Reset in the middle of bit 7 of the readout.
    randomize_smp();
    queue_block(0, 1'b0);
    v0 = valid_cnt;
    start_block(0);
    n = 0;
    while (!(bus.CS == 1'b0 && adc_bit == 7) && n < 500) begin
      tick(1);
      n++;
    end
    check("mid_rst_reached_bit7", adc_bit, 7);
    RST = 1'b1;
    tick(1);
    check("mid_rst_cs", bus.CS, 1'b1);
    check("mid_rst_sclk", bus.SCLK, 1'b1);
    check("mid_rst_valid", bus.adc_valid, 1'b0);
    check("mid_rst_data", bus.adc_data, '0);
    check("mid_rst_state", debug_state, 3'd0);
    RST = 1'b0;
    tick(200);
    check("mid_rst_no_valid", valid_cnt - v0, 0);
    check("mid_rst_ready", bus.adc_ready, 1'b1);
    conv_q.delete();

    // Start held high: exactly one block.
    busy_len = 3;
    randomize_smp();
    queue_block(0, 1'b1);
    v0 = valid_cnt; p0 = cnv_pulses;
    bus.avg_log2 = 2'd0;
    bus.start = 1'b1;
    tick(200);
    bus.start = 1'b0;
    tick(20);
    finish_block(500, "held");
    check("held_valids", valid_cnt - v0, 1);
    check("held_cnvst", cnv_pulses - p0, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
